// File: rtl/wb_mem_unit.sv
// rtl/wb_mem_unit.sv - multi-channel pipelined Wishbone memory master
module wb_mem_unit #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int ARB_RR  = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        i_req,
    input  logic [N_CH-1:0]        i_we,
    input  logic [N_CH*ADDR_W-1:0] i_addr,
    input  logic [N_CH*32-1:0]     i_wdata,
    input  logic [N_CH*2-1:0]      i_width,
    input  logic [N_CH-1:0]        i_signed,
    output logic [31:0]            o_rdata,
    output logic [N_CH-1:0]        o_done,
    output logic [N_CH-1:0]        o_fault,
    output logic [1:0]             o_fault_code,
    output logic                   o_busy,
    output logic [ADDR_W-1:0]      o_wb_addr,
    output logic [31:0]            o_wb_data,
    input  logic [31:0]            i_wb_data,
    output logic                   o_wb_we,
    output logic [3:0]             o_wb_sel,
    output logic                   o_wb_cyc,
    output logic                   o_wb_stb,
    input  logic                   i_wb_ack,
    input  logic                   i_wb_stl,
    input  logic                   i_wb_err
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_DONE, S_FAULT} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [1:0]        cur_width;
    logic              cur_signed;
    logic [1:0]        cur_lane;
    logic [CNT_W-1:0]  to_cnt;

    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_ch;
    logic              sel_we;
    logic              sel_signed;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_width;
    logic              misaligned;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_data;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;
    logic              bus_live;

    // Search order is rotated by rr_ptr in round-robin mode, identity otherwise.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_ch     = '0;
        sel_we     = 1'b0;
        sel_signed = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_width  = 2'b00;
        for (int i = 0; i < N_CH; i++) begin
            for (int j = 0; j < N_CH; j++) begin
                if (!gnt_valid && i_req[j] &&
                    ((ARB_RR == 0) ? (j == i) : (((int'(rr_ptr) + i) % N_CH) == j))) begin
                    gnt_valid  = 1'b1;
                    gnt_ch     = CH_W'(j);
                    sel_we     = i_we[j];
                    sel_signed = i_signed[j];
                    sel_addr   = i_addr[j*ADDR_W +: ADDR_W];
                    sel_wdata  = i_wdata[j*32 +: 32];
                    sel_width  = i_width[j*2 +: 2];
                end
            end
        end
    end

    always_comb begin
        misaligned = (sel_width == 2'b10) ||
                     (sel_width == 2'b01 && sel_addr[0]) ||
                     (sel_width == 2'b11 && sel_addr[1:0] != 2'b00);
        case (sel_width)
            2'b00:   begin lane_sel = 4'b0001 << sel_addr[1:0]; lane_data = {4{sel_wdata[7:0]}};  end
            2'b01:   begin lane_sel = 4'b0011 << sel_addr[1:0]; lane_data = {2{sel_wdata[15:0]}}; end
            default: begin lane_sel = 4'b1111;                  lane_data = sel_wdata;            end
        endcase
    end

    always_comb begin
        rd_shift = i_wb_data >> {cur_lane, 3'b000};
        case (cur_width)
            2'b00:   rd_ext = {{24{cur_signed & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   rd_ext = {{16{cur_signed & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // A stalled strobe is not yet accepted, so ack/err only count once the slave has taken it.
    assign bus_live = (state == S_WAIT_ACK) || !i_wb_stl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            cur_ch       <= '0;
            cur_width    <= 2'b00;
            cur_signed   <= 1'b0;
            cur_lane     <= 2'b00;
            to_cnt       <= '0;
            o_rdata      <= '0;
            o_done       <= '0;
            o_fault      <= '0;
            o_fault_code <= 2'b00;
            o_busy       <= 1'b0;
            o_wb_addr    <= '0;
            o_wb_data    <= '0;
            o_wb_we      <= 1'b0;
            o_wb_sel     <= 4'b0000;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
        end else begin
            o_done       <= '0;
            o_fault      <= '0;
            o_fault_code <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        cur_ch     <= gnt_ch;
                        rr_ptr     <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
                        cur_width  <= sel_width;
                        cur_signed <= sel_signed;
                        cur_lane   <= sel_addr[1:0];
                        to_cnt     <= '0;
                        o_wb_we    <= sel_we;
                        o_wb_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        o_wb_sel   <= lane_sel;
                        o_wb_data  <= lane_data;
                        o_busy     <= 1'b1;
                        if (misaligned) begin
                            state        <= S_FAULT;
                            o_fault      <= N_CH'(1) << gnt_ch;
                            o_fault_code <= 2'b01;
                        end else begin
                            state    <= S_REQ;
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                        end
                    end
                end
                S_REQ, S_WAIT_ACK: begin
                    if (bus_live && i_wb_err) begin
                        state        <= S_FAULT;
                        o_fault      <= N_CH'(1) << cur_ch;
                        o_fault_code <= 2'b10;
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                    end else if (bus_live && i_wb_ack) begin
                        state    <= S_DONE;
                        o_done   <= N_CH'(1) << cur_ch;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        if (!o_wb_we) o_rdata <= rd_ext;
                    end else if (TIMEOUT > 0 && to_cnt == CNT_LAST) begin
                        state        <= S_FAULT;
                        o_fault      <= N_CH'(1) << cur_ch;
                        o_fault_code <= 2'b11;
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == S_REQ && !i_wb_stl) begin
                            state    <= S_WAIT_ACK;
                            o_wb_stb <= 1'b0;
                        end
                    end
                end
                S_DONE, S_FAULT: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
